// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter.
//   op_e    : 3-bit command encoding carried on the op port
//   state_e : controller states (IDLE waits for a command, SHIFT steps it)
//   is_shift: true for the five ops that move bits one position per cycle
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_RSV  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate.
//   op : operation (shift ops move one bit; anything else passes d through)
//   d  : input word
//   q  : d moved by one position according to op
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (op)
      OP_LSL:  q = {d[WIDTH-2:0], 1'b0};
      OP_LSR:  q = {1'b0, d[WIDTH-1:1]};
      OP_ASR:  q = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  q = {d[0], d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// Sequential shifter: a k-position shift/rotate takes k cycles, one bit each.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   start, op      : command valid and opcode, sampled only in IDLE
//   shamt, d_in    : shift amount and load data for the command
//   d_out          : registered data word
//   busy           : high during every SHIFT cycle
//   done           : one-cycle pulse in the cycle after a command completes
//   dbg_state      : current controller state (0 = IDLE, 1 = SHIFT)
// Handshake: a command is taken on any rising edge where start=1 and the
// controller is IDLE (busy=0); start is ignored while busy=1, and a new
// command may be presented in the same cycle that done is high.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op (op_q),
    .d  (data_q),
    .q  (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_LOAD) begin
            data_d = d_in;
            done_d = 1'b1;
          end else if (is_shift(op) && (shamt != '0)) begin
            op_d    = op;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            // NOP, reserved, or zero-length shift: complete immediately.
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_q;
        cnt_d  = cnt_q - SHW'(1);
        // Last step: done lines up with the final data word.
        if (cnt_q == SHW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign d_out     = data_q;
  assign busy      = (state_q == ST_SHIFT);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shifter_seq.sv
module tb_shifter_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [2:0]  op;
  logic [2:0]  shamt;
  logic [7:0]  d_in, d_out;
  logic        busy, done, dbg_state;

  logic        reset16, start16;
  logic [2:0]  op16;
  logic [3:0]  shamt16;
  logic [15:0] d_in16, d_out16;
  logic        busy16, done16, dbg_state16;

  shifter_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .d_in(d_in), .d_out(d_out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  shifter_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset16), .start(start16), .op(op16), .shamt(shamt16),
    .d_in(d_in16), .d_out(d_out16), .busy(busy16), .done(done16),
    .dbg_state(dbg_state16)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] ref_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: whole-word result of a command, using plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input int k,
                                        input logic [63:0] din,
                                        input logic [63:0] v, input int w);
    logic [63:0] mask, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v = v & mask;
    r = v;
    case (o)
      3'd1: r = din & mask;
      3'd2: r = (v << k) & mask;
      3'd3: r = v >> k;
      3'd4: r = (v >> k) | ((v[w-1] && k > 0) ? (mask & ~(mask >> k)) : 64'd0);
      3'd5: r = (k == 0) ? v : (((v << k) | (v >> (w - k))) & mask);
      3'd6: r = (k == 0) ? v : (((v >> k) | (v << (w - k))) & mask);
      default: r = v;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks (8-bit instance) ----------------
  // Issues one command at posedge+1, checks busy/done per cycle and the
  // final word. With disturb set, a LOAD 00 is presented mid-shift.
  task automatic run_cmd(input logic [2:0] o, input logic [2:0] k,
                         input logic [7:0] din, input bit disturb);
    logic [7:0] exp;
    int nb;
    exp = model(o, int'(k), {56'd0, din}, ref_val, 8)[7:0];
    exp_q.push_back(exp);
    nb = (o >= 3'd2 && o <= 3'd6) ? int'(k) : 0;
    start = 1'b1; op = o; shamt = k; d_in = din;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); d_in = 8'($urandom);
    for (int i = 0; i < nb; i++) begin
      chk("busy_during_shift", busy, 1'b1);
      chk("no_done_during_shift", done, 1'b0);
      if (disturb && i == 1) begin
        start = 1'b1; op = 3'd1; d_in = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    chk("d_out_result", d_out, exp_q.pop_front());
    ref_val = {56'd0, exp};
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_no_done", done, 1'b0);
    chk("idle_hold", d_out, ref_val[7:0]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; shamt = 3'd0; d_in = 8'd0;
    reset16 = 1'b1; start16 = 1'b0; op16 = 3'd0; shamt16 = 4'd0; d_in16 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_d_out", d_out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_state", dbg_state, 1'b0);
    // Reset overrides a simultaneous start.
    start = 1'b1; op = 3'd1; d_in = 8'hAA;
    @(posedge clk); #1;
    chk("reset_over_start", d_out, 8'h00);
    start = 1'b0;
    reset = 1'b0; reset16 = 1'b0;
    idle_cycle();

    // LOAD, ASR 3, ROR 2, LSL 0 (back-to-back chain)
    run_cmd(3'd1, 3'd0, 8'hB5, 1'b0);
    chk("load_b5", d_out, 8'hB5);
    idle_cycle();
    run_cmd(3'd4, 3'd3, 8'h00, 1'b0);
    chk("asr3_f6", d_out, 8'hF6);
    run_cmd(3'd1, 3'd0, 8'hB5, 1'b0);
    run_cmd(3'd6, 3'd2, 8'h00, 1'b0);
    chk("ror2_6d", d_out, 8'h6D);
    run_cmd(3'd2, 3'd0, 8'h00, 1'b0);
    chk("lsl0_hold", d_out, 8'h6D);
    run_cmd(3'd7, 3'd5, 8'h33, 1'b0);
    chk("reserved_hold", d_out, 8'h6D);

    // LOAD pulsed during LSR 3 must be ignored
    run_cmd(3'd1, 3'd0, 8'hB5, 1'b0);
    run_cmd(3'd3, 3'd3, 8'h00, 1'b1);
    chk("lsr3_ignore_16", d_out, 8'h16);
    idle_cycle();

    // Reset in the 2nd SHIFT cycle aborts with no done
    run_cmd(3'd1, 3'd0, 8'hB5, 1'b0);
    start = 1'b1; op = 3'd3; shamt = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_d_out", d_out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_state", dbg_state, 1'b0);
    ref_val = '0;
    repeat (4) idle_cycle();

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // 16-bit instance: LOAD 8001 then ROL 15
    start16 = 1'b1; op16 = 3'd1; d_in16 = 16'h8001;
    @(posedge clk); #1;
    start16 = 1'b0;
    chk("w16_load", d_out16, 16'h8001);
    chk("w16_load_done", done16, 1'b1);
    start16 = 1'b1; op16 = 3'd5; shamt16 = 4'd15;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("w16_busy", busy16, 1'b1);
      @(posedge clk); #1;
    end
    chk("w16_rol15", d_out16, 16'hC000);
    chk("w16_model", d_out16, model(3'd5, 15, 64'd0, 64'h8001, 16));
    chk("w16_done", done16, 1'b1);
    chk("w16_busy_low", busy16, 1'b0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
